// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
// Holds the FSM state encoding, the slice width and the operand-width legality check.
package nibble_serial_adder_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Operands must split into a whole number of slice-wide nibbles.
  function automatic bit width_ok(input int w);
    return (w >= NIBBLE_W) && ((w % NIBBLE_W) == 0);
  endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_nibble_cla4.sv
// Combinational 4-bit carry-lookahead slice.
// All carries come from generate/propagate terms of this nibble, not from a ripple chain.
module nibble_cla4
  import nibble_serial_adder_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_a,
  input  logic [NIBBLE_W-1:0] i_b,
  input  logic                i_cin,
  output logic [NIBBLE_W-1:0] o_sum,
  output logic                o_cout
);

  logic [NIBBLE_W-1:0] w_g;
  logic [NIBBLE_W-1:0] w_p;
  logic [NIBBLE_W:0]   w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_sum  = w_p ^ w_c[NIBBLE_W-1:0];
  assign o_cout = w_c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract sequenced through one 4-bit CLA slice, LSB nibble first,
// with valid/ready handshakes on the request and result sides.
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_busy
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("nibble_serial_adder_ctrl: WIDTH must be a positive multiple of 4");
  end

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_cout;
  logic               r_ovf;
  logic [NIBBLE_W-1:0] r_res_nib [NIB];

  logic [NIBBLE_W-1:0] w_a_nibs [NIB];
  logic [NIBBLE_W-1:0] w_b_nibs [NIB];
  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;
  logic [NIBBLE_W-1:0] w_sum;
  logic                w_slice_cout;
  logic                w_accept;
  logic                w_run;
  logic                w_last;
  logic                w_msb_cin;

  assign w_accept = (r_state == S_IDLE) && i_in_valid;
  assign w_run    = (r_state == S_RUN);
  assign w_last   = w_run && (r_cnt == CNT_W'(NIB - 1));

  // Nibble views of the operand registers, selected by the counter.
  for (genvar gi = 0; gi < NIB; gi++) begin : g_nib_view
    assign w_a_nibs[gi] = r_a[gi*NIBBLE_W +: NIBBLE_W];
    assign w_b_nibs[gi] = r_b[gi*NIBBLE_W +: NIBBLE_W];
  end

  assign w_a_nib = w_a_nibs[r_cnt];
  assign w_b_nib = w_b_nibs[r_cnt];

  nibble_cla4 u_slice (
    .i_a    (w_a_nib),
    .i_b    (w_b_nib),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_slice_cout)
  );

  // Carry into the sign bit, recovered from its sum bit; only meaningful on the last nibble.
  assign w_msb_cin = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_sum[NIBBLE_W-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_in_ready   = 1'b0;
    o_out_valid  = 1'b0;
    o_busy       = 1'b1;
    case (r_state)
      S_IDLE: begin
        o_in_ready = 1'b1;
        o_busy     = 1'b0;
        if (i_in_valid) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= i_op_a;
      r_b     <= i_sub ? ~i_op_b : i_op_b;
      r_carry <= i_sub ? 1'b1 : i_cin;
      r_cnt   <= '0;
    end else if (w_run) begin
      r_carry <= w_slice_cout;
      if (w_last) begin
        r_cnt  <= '0;
        r_cout <= w_slice_cout;
        r_ovf  <= w_msb_cin ^ w_slice_cout;
      end else begin
        r_cnt  <= r_cnt + CNT_W'(1);
      end
    end
  end

  for (genvar gi = 0; gi < NIB; gi++) begin : g_res
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_res_nib[gi] <= '0;
      end else if (w_accept) begin
        r_res_nib[gi] <= '0;
      end else if (w_run && (r_cnt == CNT_W'(gi))) begin
        r_res_nib[gi] <= w_sum;
      end
    end
    assign o_result[gi*NIBBLE_W +: NIBBLE_W] = r_res_nib[gi];
  end

  assign o_cout = r_cout;
  assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl: directed table, handshake corner
// cases, mid-operation reset and randomized operations against an integer model.
module tb_nibble_serial_adder_ctrl;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_in_valid;
  logic          o_in_ready;
  logic [W-1:0]  i_op_a;
  logic [W-1:0]  i_op_b;
  logic          i_cin;
  logic          i_sub;
  logic          o_out_valid;
  logic          i_out_ready;
  logic [W-1:0]  o_result;
  logic          o_cout;
  logic          o_ovf;
  logic          o_busy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 i_clk = ~i_clk;

  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_op_a      (i_op_a),
    .i_op_b      (i_op_b),
    .i_cin       (i_cin),
    .i_sub       (i_sub),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_result    (o_result),
    .o_cout      (o_cout),
    .o_ovf       (o_ovf),
    .o_busy      (o_busy)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else
      n_pass++;
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic s, output logic [W-1:0] r, output logic co,
                       output logic ov);
    int ua, ub, sa, sb, sres, ures;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (s) begin
      ures = ua - ub;
      co   = (ua >= ub);
      sres = sa - sb;
    end else begin
      ures = ua + ub + int'(c);
      co   = (ures > 65535);
      sres = sa + sb + int'(c);
    end
    r  = ures[W-1:0];
    ov = (sres > 32767) || (sres < -32768);
  endtask

  // Called away from an edge while idle; returns #1 after the accept edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic s);
    i_op_a     = a;
    i_op_b     = b;
    i_cin      = c;
    i_sub      = s;
    i_in_valid = 1'b1;
    chk("in_ready_before_accept", {31'd0, o_in_ready}, 32'd1);
    @(posedge i_clk);
    #1;
    i_in_valid = 1'b0;
    i_op_a     = W'($urandom);
    i_op_b     = W'($urandom);
    i_cin      = 1'($urandom);
    i_sub      = 1'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (o_out_valid !== 1'b1 && lat < 20) begin
      chk("run_ready_busy", {30'd0, o_in_ready, o_busy}, 32'd1);
      @(posedge i_clk);
      #1;
      lat++;
    end
    chk("out_valid_seen", {31'd0, o_out_valid}, 32'd1);
  endtask

  task automatic finish_op();
    i_out_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_out_ready = 1'b0;
    chk("idle_after_handshake", {30'd0, o_out_valid, o_in_ready}, 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] r,
                              input logic co, input logic ov);
    chk({tag, "_result"}, {16'd0, o_result}, {16'd0, r});
    chk({tag, "_cout"},   {31'd0, o_cout},   {31'd0, co});
    chk({tag, "_ovf"},    {31'd0, o_ovf},    {31'd0, ov});
  endtask

  initial begin
    logic [W-1:0] m_r;
    logic         m_co;
    logic         m_ov;
    int           lat;
    logic [W-1:0] held_res;
    logic         held_co;

    vecs[0] = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};

    i_rst_n     = 1'b0;
    i_in_valid  = 1'b0;
    i_out_ready = 1'b0;
    i_op_a      = '0;
    i_op_b      = '0;
    i_cin       = 1'b0;
    i_sub       = 1'b0;
    #1;
    chk("reset_in_ready",  {31'd0, o_in_ready},  32'd1);
    chk("reset_out_valid", {31'd0, o_out_valid}, 32'd0);
    chk("reset_busy",      {31'd0, o_busy},      32'd0);
    check_result("reset", '0, 1'b0, 1'b0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Directed table
    for (int i = 0; i < 6; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      wait_done(lat);
      chk("latency", lat, NIB);
      check_result("vec", vecs[i].res, vecs[i].cout, vecs[i].ovf);
      $display("vec %0d: a=%h b=%h cin=%b sub=%b -> res=%h cout=%b ovf=%b lat=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, o_result, o_cout, o_ovf, lat);
      finish_op();
    end

    // Backpressure in DONE while a new request is held pending
    start_op(16'hA5A5, 16'h1111, 1'b0, 1'b0);
    wait_done(lat);
    held_res   = o_result;
    held_co    = o_cout;
    chk("bp_first_result", {16'd0, held_res}, 32'h0000B6B6);
    i_op_a     = 16'h0100;
    i_op_b     = 16'h0001;
    i_cin      = 1'b0;
    i_sub      = 1'b1;
    i_in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge i_clk);
      #1;
      chk("bp_out_valid", {31'd0, o_out_valid}, 32'd1);
      chk("bp_result",    {16'd0, o_result},    {16'd0, held_res});
      chk("bp_cout",      {31'd0, o_cout},      {31'd0, held_co});
      chk("bp_in_ready",  {31'd0, o_in_ready},  32'd0);
    end
    i_out_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_out_ready = 1'b0;
    chk("bp_idle_cycle", {30'd0, o_in_ready, o_busy}, 32'd2);
    chk("bp_result_kept_idle", {16'd0, o_result}, {16'd0, held_res});
    @(posedge i_clk);
    #1;
    i_in_valid = 1'b0;
    chk("bp_second_accept", {30'd0, o_in_ready, o_busy}, 32'd1);
    wait_done(lat);
    chk("bp_second_latency", lat, NIB);
    check_result("bp_second", 16'h00FF, 1'b1, 1'b0);
    $display("backpressure: held=%h second=%h cout=%b", held_res, o_result, o_cout);
    finish_op();

    // Reset in the middle of RUN
    start_op(16'h1234, 16'h1111, 1'b0, 1'b0);
    @(posedge i_clk);
    #1;
    @(posedge i_clk);
    #1;
    chk("mid_partial_result", {16'd0, o_result}, 32'h00000045);
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready",  {31'd0, o_in_ready},  32'd1);
    chk("mid_rst_out_valid", {31'd0, o_out_valid}, 32'd0);
    chk("mid_rst_busy",      {31'd0, o_busy},      32'd0);
    check_result("mid_rst", '0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      chk("rst_no_valid", {31'd0, o_out_valid}, 32'd0);
    end
    i_rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge i_clk);
      #1;
      chk("post_rst_idle", {30'd0, o_out_valid, o_in_ready}, 32'd1);
    end
    start_op(16'h0F0F, 16'h0101, 1'b1, 1'b0);
    wait_done(lat);
    chk("post_rst_latency", lat, NIB);
    check_result("post_rst", 16'h1011, 1'b0, 1'b0);
    $display("post-reset op: res=%h", o_result);
    finish_op();

    // Randomized operations against the integer model
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic         rc, rs;
      int           hold;
      ra   = W'($urandom);
      rb   = W'($urandom);
      rc   = 1'($urandom);
      rs   = 1'($urandom);
      hold = int'($urandom_range(0, 2));
      if (i % 8 == 0) ra[W-1:W-4] = 4'hF;
      model(ra, rb, rc, rs, m_r, m_co, m_ov);
      start_op(ra, rb, rc, rs);
      wait_done(lat);
      chk("rand_latency", lat, NIB);
      for (int k = 0; k < hold; k++) begin
        @(posedge i_clk);
        #1;
      end
      check_result("rand", m_r, m_co, m_ov);
      $display("rand %0d: a=%h b=%h cin=%b sub=%b -> res=%h (exp %h) cout=%b ovf=%b",
               i, ra, rb, rc, rs, o_result, m_r, o_cout, o_ovf);
      finish_op();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
